// File: rtl/dbus_pkg.sv
// Shared constants for the data-bus responder: MMIO window base, register
// offsets, STATUS/CTRL bit positions and the misaligned-read pattern.
package dbus_pkg;

    localparam logic [1:0] MMIO_BASE = 2'b11;

    localparam logic [7:0] MTIME_OFF    = 8'h00;
    localparam logic [7:0] MTIMECMP_OFF = 8'h04;
    localparam logic [7:0] GPIO_OUT_OFF = 8'h08;
    localparam logic [7:0] GPIO_IN_OFF  = 8'h0C;
    localparam logic [7:0] STATUS_OFF   = 8'h10;
    localparam logic [7:0] PRESCALE_OFF = 8'h14;
    localparam logic [7:0] CTRL_OFF     = 8'h18;

    localparam int unsigned STATUS_TPEND_BIT = 0;
    localparam int unsigned STATUS_MISAL_BIT = 1;
    localparam int unsigned CTRL_TIE_BIT     = 0;
    localparam int unsigned CTRL_TEN_BIT     = 1;

    localparam logic [31:0] DEADBEEF_C = 32'hDEAD_BEEF;

    // Register select as seen on daddr[7:2]
    typedef enum logic [5:0] {
        REG_MTIME    = 6'(MTIME_OFF    >> 2),
        REG_MTIMECMP = 6'(MTIMECMP_OFF >> 2),
        REG_GPIO_OUT = 6'(GPIO_OUT_OFF >> 2),
        REG_GPIO_IN  = 6'(GPIO_IN_OFF  >> 2),
        REG_STATUS   = 6'(STATUS_OFF   >> 2),
        REG_PRESCALE = 6'(PRESCALE_OFF >> 2),
        REG_CTRL     = 6'(CTRL_OFF     >> 2)
    } mmio_reg_e;

endpackage

// File: rtl/dbus_timer.sv
// Prescaled MTIME counter with MTIMECMP compare and sticky tpend flag.
module dbus_timer
    import dbus_pkg::*;
#(
    parameter logic [31:0] PRESCALE_RST = 32'd0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ten,
    input  logic [31:0] wdata,
    input  logic        mtime_we,
    input  logic        mtimecmp_we,
    input  logic        prescale_we,
    input  logic        tpend_clr,
    output logic [31:0] mtime,
    output logic [31:0] mtimecmp,
    output logic [31:0] prescale,
    output logic        tpend
);

    logic [31:0] pc;
    logic        tick;
    logic        tpend_set;

    always_comb begin
        tick      = ten && (pc == prescale);
        tpend_set = tick && ((mtime + 32'd1) == mtimecmp);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc       <= '0;
            mtime    <= '0;
            mtimecmp <= '1;
            prescale <= PRESCALE_RST;
            tpend    <= 1'b0;
        end else begin
            if (prescale_we) begin
                pc <= '0;
            end else if (ten) begin
                pc <= tick ? '0 : pc + 32'd1;
            end

            // A core write to MTIME takes priority over the tick increment
            if (mtime_we) begin
                mtime <= wdata;
            end else if (tick) begin
                mtime <= mtime + 32'd1;
            end

            if (mtimecmp_we) begin
                mtimecmp <= wdata;
            end
            if (prescale_we) begin
                prescale <= wdata;
            end

            if (tpend_set) begin
                tpend <= 1'b1;
            end else if (tpend_clr) begin
                tpend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus slave: 192-word RAM plus timer/GPIO/status MMIO window at 0x300.
// Optional alignment checking is enabled by defining DBUS_ALIGN_CHECK_EN.
module dbus_responder
    import dbus_pkg::*;
#(
    parameter int unsigned RAM_WORDS    = 192,
    parameter int unsigned GPIO_W       = 8,
    parameter logic [31:0] PRESCALE_RST = 32'd0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [9:0]        daddr,
    input  logic [31:0]       ddata_w,
    input  logic              d_rw,
    output logic [31:0]       ddata_r,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq,
    output logic              misaligned_err
);

    logic [31:0]       mem [RAM_WORDS];
    logic [GPIO_W-1:0] gpio_out_q;
    logic [GPIO_W-1:0] gpio_meta;
    logic [GPIO_W-1:0] gpio_sync;
    logic [1:0]        ctrl_q;
    logic [31:0]       mtime;
    logic [31:0]       mtimecmp;
    logic [31:0]       prescale;
    logic              tpend;
    logic              misal_now;
    logic              misal_flag;
    logic              wr_en;
    logic              is_mmio;
    logic              ram_we;
    logic              mmio_we;
    logic              status_we;
    mmio_reg_e         sel;
    logic [31:0]       rdata;

`ifdef DBUS_ALIGN_CHECK_EN
    logic misal_q;

    assign misal_now = (daddr[1:0] != 2'b00);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            misal_q <= 1'b0;
        end else if (misal_now) begin
            misal_q <= 1'b1;
        end else if (status_we && ddata_w[STATUS_MISAL_BIT]) begin
            misal_q <= 1'b0;
        end
    end

    assign misal_flag = misal_q;
`else
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^daddr[1:0];
    assign misal_now       = 1'b0;
    assign misal_flag      = 1'b0;
`endif

    always_comb begin
        sel       = mmio_reg_e'(daddr[7:2]);
        is_mmio   = (daddr[9:8] == MMIO_BASE);
        wr_en     = d_rw && !misal_now;
        ram_we    = wr_en && !is_mmio;
        mmio_we   = wr_en && is_mmio;
        status_we = mmio_we && (sel == REG_STATUS);
    end

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem[daddr[9:2]] <= ddata_w;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            gpio_out_q <= '0;
            gpio_meta  <= '0;
            gpio_sync  <= '0;
            ctrl_q     <= '0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
            if (mmio_we && (sel == REG_GPIO_OUT)) begin
                gpio_out_q <= ddata_w[GPIO_W-1:0];
            end
            if (mmio_we && (sel == REG_CTRL)) begin
                ctrl_q <= ddata_w[1:0];
            end
        end
    end

    dbus_timer #(
        .PRESCALE_RST (PRESCALE_RST)
    ) u_timer (
        .CLK         (CLK),
        .RESET       (RESET),
        .ten         (ctrl_q[CTRL_TEN_BIT]),
        .wdata       (ddata_w),
        .mtime_we    (mmio_we && (sel == REG_MTIME)),
        .mtimecmp_we (mmio_we && (sel == REG_MTIMECMP)),
        .prescale_we (mmio_we && (sel == REG_PRESCALE)),
        .tpend_clr   (status_we && ddata_w[STATUS_TPEND_BIT]),
        .mtime       (mtime),
        .mtimecmp    (mtimecmp),
        .prescale    (prescale),
        .tpend       (tpend)
    );

    always_comb begin
        rdata = '0;
        if (misal_now) begin
            rdata = DEADBEEF_C;
        end else if (!is_mmio) begin
            rdata = mem[daddr[9:2]];
        end else begin
            case (sel)
                REG_MTIME:    rdata = mtime;
                REG_MTIMECMP: rdata = mtimecmp;
                REG_GPIO_OUT: rdata = 32'(gpio_out_q);
                REG_GPIO_IN:  rdata = 32'(gpio_sync);
                REG_STATUS: begin
                    rdata[STATUS_TPEND_BIT] = tpend;
                    rdata[STATUS_MISAL_BIT] = misal_flag;
                end
                REG_PRESCALE: rdata = prescale;
                REG_CTRL:     rdata[1:0] = ctrl_q;
                default:      rdata = '0;
            endcase
        end
    end

    assign ddata_r        = rdata;
    assign gpio_out       = gpio_out_q;
    assign timer_irq      = tpend && ctrl_q[CTRL_TIE_BIT];
    assign misaligned_err = misal_flag;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed-vector bench for dbus_responder: RAM, MMIO timer/GPIO/status, reset.
module tb_dbus_responder;

    localparam logic [9:0] A_MTIME    = 10'h300;
    localparam logic [9:0] A_MTIMECMP = 10'h304;
    localparam logic [9:0] A_GPIO_OUT = 10'h308;
    localparam logic [9:0] A_GPIO_IN  = 10'h30C;
    localparam logic [9:0] A_STATUS   = 10'h310;
    localparam logic [9:0] A_PRESCALE = 10'h314;
    localparam logic [9:0] A_CTRL     = 10'h318;

    logic        CLK;
    logic        RESET;
    logic [9:0]  daddr;
    logic [31:0] ddata_w;
    logic        d_rw;
    logic [31:0] ddata_r;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;
    logic        misaligned_err;

    int unsigned n_checks;
    int unsigned n_pass;
    logic [31:0] v;

    dbus_responder #(
        .RAM_WORDS    (192),
        .GPIO_W       (8),
        .PRESCALE_RST (32'd0)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .daddr          (daddr),
        .ddata_w        (ddata_w),
        .d_rw           (d_rw),
        .ddata_r        (ddata_r),
        .gpio_in        (gpio_in),
        .gpio_out       (gpio_out),
        .timer_irq      (timer_irq),
        .misaligned_err (misaligned_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        daddr   = a;
        ddata_w = d;
        d_rw    = 1'b1;
        @(posedge CLK);
        #1;
        d_rw = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] q);
        daddr = a;
        d_rw  = 1'b0;
        #1;
        q = ddata_r;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        RESET    = 1'b0;
        daddr    = '0;
        ddata_w  = '0;
        d_rw     = 1'b0;
        gpio_in  = '0;
        #1 RESET = 1'b1;
        #2;

        // Reset state
        rd(A_MTIME, v);    check("rst_mtime", v, 32'h0);
        rd(A_MTIMECMP, v); check("rst_mtimecmp", v, 32'hFFFF_FFFF);
        rd(A_PRESCALE, v); check("rst_prescale", v, 32'h0);
        rd(A_CTRL, v);     check("rst_ctrl", v, 32'h0);
        rd(A_STATUS, v);   check("rst_status", v, 32'h0);
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        check("rst_misal", 32'(misaligned_err), 32'h0);
        @(negedge CLK) RESET = 1'b0;
        tick();

        // RAM and unmapped MMIO
        wr(10'h010, 32'h1234_5678);
        rd(10'h010, v); check("ram_010", v, 32'h1234_5678);
        wr(10'h2FC, 32'hA5A5_A5A5);
        rd(10'h2FC, v); check("ram_2fc", v, 32'hA5A5_A5A5);
        rd(10'h010, v); check("ram_010_kept", v, 32'h1234_5678);
        wr(10'h3FC, 32'hFFFF_FFFF);
        rd(10'h3FC, v); check("unmapped_3fc", v, 32'h0);
        wr(10'h31C, 32'h1111_1111);
        rd(10'h31C, v); check("unmapped_31c", v, 32'h0);

        // GPIO synchroniser and output register
        gpio_in = 8'h5A;
        tick();
        rd(A_GPIO_IN, v); check("gpio_in_n1", v, 32'h0);
        tick();
        rd(A_GPIO_IN, v); check("gpio_in_n2", v, 32'h5A);
        check("gpio_out_pre", 32'(gpio_out), 32'h0);
        wr(A_GPIO_OUT, 32'hFFFF_FF3C);
        check("gpio_out_3c", 32'(gpio_out), 32'h3C);
        rd(A_GPIO_OUT, v); check("gpio_out_rd", v, 32'h3C);

        // Timer: prescale 3, compare 5, count enabled without interrupt
        wr(A_PRESCALE, 32'd3);
        wr(A_MTIMECMP, 32'd5);
        wr(A_CTRL, 32'b10);
        rd(A_MTIME, v); check("mtime_t0", v, 32'd0);
        tick(); tick(); tick();
        rd(A_MTIME, v); check("mtime_t3", v, 32'd0);
        tick();
        rd(A_MTIME, v); check("mtime_t4", v, 32'd1);
        rd(A_STATUS, v); check("tpend_early", v, 32'h0);
        check("irq_early", 32'(timer_irq), 32'h0);
        for (int i = 0; i < 40; i++) begin
            tick();
            rd(A_MTIME, v);
            if (v == 32'd5) break;
        end
        check("mtime_reach5", v, 32'd5);
        rd(A_STATUS, v); check("tpend_set", v, 32'h1);
        check("irq_masked", 32'(timer_irq), 32'h0);
        wr(A_CTRL, 32'b11);
        check("irq_tie", 32'(timer_irq), 32'h1);
        wr(A_STATUS, 32'h1);
        rd(A_STATUS, v); check("tpend_w1c", v, 32'h0);
        check("irq_w1c", 32'(timer_irq), 32'h0);

        // Collisions with a tick every cycle
        wr(A_PRESCALE, 32'd0);
        wr(A_MTIME, 32'hFFFF_FFFF);
        rd(A_MTIME, v); check("mtime_wr_ffff", v, 32'hFFFF_FFFF);
        tick();
        rd(A_MTIME, v); check("mtime_wrap", v, 32'h0);
        wr(A_MTIME, 32'h100);
        rd(A_MTIME, v); check("mtime_wr_wins", v, 32'h100);
        wr(A_MTIME, 32'h200);
        wr(A_MTIMECMP, 32'h203);
        wr(A_STATUS, 32'h1);
        rd(A_STATUS, v); check("tpend_pre_match", v, 32'h0);
        wr(A_STATUS, 32'h1);
        rd(A_STATUS, v); check("tpend_set_wins", v, 32'h1);

        // Asynchronous reset mid-count
        wr(A_CTRL, 32'b11);
        wr(A_GPIO_OUT, 32'hFF);
        check("gpio_out_ff", 32'(gpio_out), 32'hFF);
        check("irq_pre_rst", 32'(timer_irq), 32'h1);
        #2 RESET = 1'b1;
        #1;
        check("rst_async_gpio", 32'(gpio_out), 32'h0);
        check("rst_async_irq", 32'(timer_irq), 32'h0);
        rd(A_MTIME, v);  check("rst_async_mtime", v, 32'h0);
        rd(A_STATUS, v); check("rst_async_status", v, 32'h0);
        rd(10'h010, v);  check("rst_ram_kept", v, 32'h1234_5678);
        @(negedge CLK) RESET = 1'b0;
        tick();

`ifdef DBUS_ALIGN_CHECK_EN
        wr(10'h012, 32'h11);
        check("misal_err_set", 32'(misaligned_err), 32'h1);
        rd(10'h012, v); check("misal_rd", v, 32'hDEAD_BEEF);
        rd(10'h010, v); check("misal_wr_blocked", v, 32'h1234_5678);
        rd(A_STATUS, v); check("misal_status", v, 32'h2);
        wr(A_STATUS, 32'h2);
        check("misal_w1c", 32'(misaligned_err), 32'h0);
`else
        wr(10'h012, 32'hCAFE_F00D);
        rd(10'h010, v); check("unaligned_wr_word", v, 32'hCAFE_F00D);
        rd(10'h013, v); check("unaligned_rd_word", v, 32'hCAFE_F00D);
        check("misal_err_tied", 32'(misaligned_err), 32'h0);
        rd(A_STATUS, v); check("misal_status_zero", v, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Slave (responder) end of the RV32I core's data bus.
- Serves the core's `daddr`, `ddata_w` and `d_rw` with a 192-word data RAM plus a memory-mapped peripheral window (timer, GPIO, status).
- Read data is combinational, so the single-cycle core completes loads in the same cycle. Writes commit on the next rising `CLK`.
- Sits beside the core at top level, in place of a bare data RAM.

Parameters:
- RAM_WORDS, 192, number of 32-bit RAM words at byte addresses 0x000-0x2FF.
- GPIO_W, 8, width of the GPIO input and output ports.
- PRESCALE_RST, 0, reset value of the PRESCALE register.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- daddr  in  10  byte address from core.
- ddata_w  in  32  write data from core.
- d_rw  in  1  1 = write this cycle, 0 = read.
- ddata_r  out  32  read data to core, combinational from daddr.
- gpio_in  in  GPIO_W  asynchronous external inputs.
- gpio_out  out  GPIO_W  registered outputs.
- timer_irq  out  1  STATUS.tpend AND CTRL.tie.
- misaligned_err  out  1  sticky misalignment flag; tied to 0 without the optional feature.

Behaviour:
- Address decode:
  - daddr[9:8] != 2'b11: RAM, word index daddr[9:2].
  - daddr[9:8] == 2'b11: MMIO, register select daddr[7:2].
  - Unmapped MMIO reads return 0; writes to them are ignored.
- RAM:
  - Asynchronous read.
  - Synchronous write when d_rw=1.
  - Contents are not reset.
  - Write then read of the same address in the next cycle returns the new data.
- MMIO map (byte offsets):
  - 0x300 MTIME, R/W.
  - 0x304 MTIMECMP, R/W.
  - 0x308 GPIO_OUT, R/W, low GPIO_W bits.
  - 0x30C GPIO_IN, RO, synchronised value.
  - 0x310 STATUS: bit0 tpend (W1C), bit1 misal (W1C).
  - 0x314 PRESCALE, R/W.
  - 0x318 CTRL: bit0 tie, bit1 ten.
- Reset values:
  - MTIME = 0, MTIMECMP = 0xFFFFFFFF, GPIO_OUT = 0, STATUS = 0, PRESCALE = PRESCALE_RST, CTRL = 0.
  - Both sync stages = 0.
  - timer_irq = 0, gpio_out = 0, misaligned_err = 0.
- Timer:
  - 32-bit prescale counter pc. When CTRL.ten=1, pc increments each cycle.
  - When pc == PRESCALE: pc <= 0, a tick occurs, and MTIME <= MTIME+1.
  - MTIME wraps 0xFFFFFFFF -> 0.
  - ten=0 holds both pc and MTIME.
  - Writing PRESCALE clears pc.
- Compare:
  - tpend sets on a tick where MTIME+1 == MTIMECMP.
  - Once set, tpend stays set until cleared by W1C.
- Simultaneous events:
  - A core write to MTIME in the same cycle as a tick: the write wins and the increment is lost.
  - W1C of tpend in the same cycle as a set condition: set wins.
  - A write to MTIMECMP takes effect for comparisons from the next cycle.
- GPIO_IN: two-flop synchronizer. A gpio_in change is readable at 0x30C two rising edges later.
- gpio_out follows the GPIO_OUT register directly, one cycle after the write.
- RESET asserted mid-operation: all registers clear immediately (asynchronous); RAM is untouched.

Optional Feature:
- Macro DBUS_ALIGN_CHECK_EN.
- Defined: any access with daddr[1:0] != 0 is handled as follows.
  - Write is suppressed.
  - Read returns 0xDEADBEEF.
  - STATUS.misal sets; misaligned_err mirrors STATUS.misal.
  - W1C clears the flag unless a new misaligned access occurs in the same cycle (set wins).
- Undefined:
  - daddr[1:0] is ignored: the access goes to the aligned word.
  - STATUS.misal reads 0.
  - misaligned_err is tied to 0.

Decomposition:
- Package dbus_pkg:
  - MMIO offset localparams (MTIME_OFF ... CTRL_OFF).
  - MMIO_BASE (2'b11 on daddr[9:8]).
  - STATUS/CTRL bit-index constants.
  - DEADBEEF_C.
- Sub-module dbus_timer: owns the prescaler, MTIME, MTIMECMP and tpend set logic.
  - Inputs: write strobes/data and the W1C clear.
  - Outputs: MTIME, MTIMECMP, tpend.
- The decode, RAM, GPIO and status logic stay in dbus_responder.

Test Plan:
- RAM: write 0x12345678 to 0x010, read 0x010 next cycle -> 0x12345678; read 0x2FC after a write of 0xA5A5A5A5 -> 0xA5A5A5A5; read 0x3FC -> 0.
- Timer: PRESCALE=3, CTRL=0b10, MTIMECMP=5 -> MTIME reads 1 after 4 cycles; tpend/timer_irq stay 0 with tie=0; set tie=1 -> timer_irq=1 once MTIME reaches 5; W1C of 0x1 to STATUS -> 0.
- Collisions:
  - Write MTIME=0xFFFFFFFF with PRESCALE=0: next tick -> MTIME=0.
  - Write MTIME=0x100 coincident with a tick -> MTIME=0x100.
  - W1C coincident with a match -> tpend stays 1.
- GPIO: drive gpio_in=0x5A at cycle N -> a read of 0x30C returns 0x5A from cycle N+2, and 0x00 at N+1; write GPIO_OUT=0x3C -> gpio_out=0x3C next cycle.
- Reset: assert RESET mid-count with gpio_out=0xFF, tpend=1 -> immediately gpio_out=0, timer_irq=0, MTIME=0; RAM word 0x010 still reads 0x12345678.
- With DBUS_ALIGN_CHECK_EN: write 0x11 to 0x012 -> RAM word 0x010 unchanged, misaligned_err=1, read 0x012 -> 0xDEADBEEF.
